// File: rtl/fp_op_scheduler.sv
// Round-robin scheduler sharing one pipelined FP unit among NUM_REQ requesters, with credits,
// reserved-opcode NaN replies and a flush/drain FSM. Define FP_SCHED_STATS_EN for issue/stall counters.
module fp_op_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int MAX_OUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]  req_op,
  output logic                  fpu_valid,
  output logic [31:0]           fpu_a,
  output logic [31:0]           fpu_b,
  output logic [1:0]            fpu_op,
  output logic [2:0]            fpu_tag,
  input  logic                  fpu_res_valid,
  input  logic [31:0]           fpu_res,
  input  logic [2:0]            fpu_res_tag,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_data,
  input  logic                  flush,
  output logic                  flush_done
`ifdef FP_SCHED_STATS_EN
  ,
  output logic [31:0]           stat_issue,
  output logic [31:0]           stat_stall
`endif
);

  typedef struct packed {
    logic        sign;
    logic [7:0]  biased_exponent;
    logic [22:0] mantissa;
  } float_t;

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, FLUSHED = 2'd2} state_t;

  localparam logic [1:0]  OP_RSVD = 2'b11;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  state_t             state_reg;
  logic               flush_done_reg;
  logic [3:0]         out_cnt;
  logic [2:0]         rr_ptr_reg;
  logic               nan_pend_reg;
  logic [2:0]         nan_tag_reg;
  logic               err_underflow;
  logic               fpu_valid_reg;
  float_t             fpu_a_reg;
  float_t             fpu_b_reg;
  logic [1:0]         fpu_op_reg;
  logic [2:0]         fpu_tag_reg;
  logic [NUM_REQ-1:0] rsp_valid_reg;
  logic [31:0]        rsp_data_reg;

  logic [NUM_REQ-1:0] rsvd;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] res_oh;
  logic [NUM_REQ-1:0] nan_oh;
  logic [NUM_REQ-1:0] grant_oh;
  logic               credit_ok;
  logic               grant_en;
  logic               grant_any;
  logic               grant_rsvd;
  logic               issue;
  logic               res_ok;
  logic [2:0]         grant_idx;
  float_t             sel_a;
  float_t             sel_b;
  logic [1:0]         sel_op;
  logic [3:0]         out_cnt_next;
  logic               nan_pend_next;
  logic               drained_next;

  // A returning result frees its slot in the same cycle, so a full unit can still accept one op.
  assign credit_ok = (out_cnt < 4'(MAX_OUT)) || fpu_res_valid;
  assign grant_en  = !rst && (state_reg == RUN) && !flush;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign rsvd[gi]   = (req_op[2*gi +: 2] == OP_RSVD);
      assign cand[gi]   = req_valid[gi] && (rsvd[gi] ? !nan_pend_reg : credit_ok);
      assign res_oh[gi] = (fpu_res_tag == 3'(gi));
      assign nan_oh[gi] = (nan_tag_reg == 3'(gi));
    end
  endgenerate

  always_comb begin
    grant_any  = 1'b0;
    grant_idx  = '0;
    grant_oh   = '0;
    grant_rsvd = 1'b0;
    sel_a      = '0;
    sel_b      = '0;
    sel_op     = '0;
    if (grant_en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        for (int j = 0; j < NUM_REQ; j++) begin
          if (!grant_any && cand[j] && (((int'(rr_ptr_reg) + k) % NUM_REQ) == j)) begin
            grant_any  = 1'b1;
            grant_idx  = 3'(j);
            grant_oh[j] = 1'b1;
            grant_rsvd = rsvd[j];
            sel_a      = req_a[32*j +: 32];
            sel_b      = req_b[32*j +: 32];
            sel_op     = req_op[2*j +: 2];
          end
        end
      end
    end
  end

  assign req_ready = grant_oh;
  assign issue     = grant_any && !grant_rsvd;
  assign res_ok    = fpu_res_valid && (out_cnt != 4'd0);

  always_comb begin
    out_cnt_next = out_cnt;
    if (issue && !res_ok)
      out_cnt_next = out_cnt + 4'd1;
    else if (!issue && res_ok)
      out_cnt_next = out_cnt - 4'd1;
  end

  // A NaN reply stays pending only when a real result owns the output in the grant cycle.
  assign nan_pend_next = res_ok && (nan_pend_reg || grant_rsvd);
  assign drained_next  = (out_cnt_next == 4'd0) && !nan_pend_next;

  // Drain completion is judged on next-cycle occupancy so flush_done rises right after the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= RUN;
      flush_done_reg <= 1'b0;
    end else begin
      flush_done_reg <= 1'b0;
      case (state_reg)
        RUN: begin
          if (flush) state_reg <= DRAIN;
        end
        DRAIN: begin
          if (!flush) begin
            state_reg <= RUN;
          end else if (drained_next) begin
            state_reg      <= FLUSHED;
            flush_done_reg <= 1'b1;
          end
        end
        FLUSHED: begin
          if (!flush) begin
            state_reg <= RUN;
          end else begin
            flush_done_reg <= 1'b1;
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt       <= '0;
      rr_ptr_reg    <= '0;
      err_underflow <= 1'b0;
      nan_pend_reg  <= 1'b0;
      nan_tag_reg   <= '0;
      fpu_valid_reg <= 1'b0;
      fpu_a_reg     <= '0;
      fpu_b_reg     <= '0;
      fpu_op_reg    <= '0;
      fpu_tag_reg   <= '0;
      rsp_valid_reg <= '0;
      rsp_data_reg  <= '0;
    end else begin
      out_cnt      <= out_cnt_next;
      nan_pend_reg <= nan_pend_next;
      if (grant_any)
        rr_ptr_reg <= (grant_idx == 3'(NUM_REQ-1)) ? 3'd0 : grant_idx + 3'd1;
      if (fpu_res_valid && (out_cnt == 4'd0))
        err_underflow <= 1'b1;
      if (res_ok && grant_rsvd)
        nan_tag_reg <= grant_idx;

      fpu_valid_reg <= issue;
      if (issue) begin
        fpu_a_reg   <= sel_a;
        fpu_b_reg   <= sel_b;
        fpu_op_reg  <= sel_op;
        fpu_tag_reg <= grant_idx;
      end

      rsp_valid_reg <= '0;
      if (res_ok) begin
        rsp_valid_reg <= res_oh;
        rsp_data_reg  <= fpu_res;
      end else if (nan_pend_reg) begin
        rsp_valid_reg <= nan_oh;
        rsp_data_reg  <= QNAN;
      end else if (grant_rsvd) begin
        rsp_valid_reg <= grant_oh;
        rsp_data_reg  <= QNAN;
      end
    end
  end

`ifdef FP_SCHED_STATS_EN
  logic [31:0]        stat_issue_reg;
  logic [31:0]        stat_stall_reg;
  logic [NUM_REQ-1:0] elig;

  assign elig = req_valid & ~rsvd;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issue_reg <= '0;
      stat_stall_reg <= '0;
    end else begin
      if (issue)
        stat_issue_reg <= stat_issue_reg + 32'd1;
      if ((|elig) && !grant_any && (!credit_ok || (state_reg != RUN) || flush))
        stat_stall_reg <= stat_stall_reg + 32'd1;
    end
  end

  assign stat_issue = stat_issue_reg;
  assign stat_stall = stat_stall_reg;
`endif

  assign fpu_valid  = fpu_valid_reg;
  assign fpu_a      = fpu_a_reg;
  assign fpu_b      = fpu_b_reg;
  assign fpu_op     = fpu_op_reg;
  assign fpu_tag    = fpu_tag_reg;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_data   = rsp_data_reg;
  assign flush_done = flush_done_reg;

endmodule

// File: doc/fp_op_scheduler.md
FP_OP_SCHEDULER -- requirements
Module: fp_op_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one FP unit, range 2..8.
REQ-002 Parameter MAX_OUT, default 4: maximum operations in flight inside the FP unit, range 1..15.
REQ-003 clk  input  1  single clock; all logic is on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  per-requester operation valid.
REQ-006 req_ready  output  NUM_REQ  per-requester accept; at most one bit is high per cycle.
REQ-007 req_a, req_b  input  NUM_REQ*32  per-requester operands as float_t (sign[31], biased_exponent[30:23], mantissa[22:0]); requester i occupies slice [32*i +: 32].
REQ-008 req_op  input  NUM_REQ*2  per-requester opcode: 00 add, 01 sub, 10 mul, 11 reserved.
REQ-009 fpu_valid  output  1  issue strobe to the shared FP unit.
REQ-010 fpu_a, fpu_b  output  32  issued operands.
REQ-011 fpu_op  output  2  issued opcode.
REQ-012 fpu_tag  output  3  issuing requester index.
REQ-013 fpu_res_valid  input  1  result strobe from the FP unit; the unit has no backpressure.
REQ-014 fpu_res  input  32  result value.
REQ-015 fpu_res_tag  input  3  tag of the returned result.
REQ-016 rsp_valid  output  NUM_REQ  one-hot result strobe; requesters cannot stall it.
REQ-017 rsp_data  output  32  result, shared by all requesters.
REQ-018 flush  input  1  request to stop issuing and drain.
REQ-019 flush_done  output  1  high while drained and flush is held.

Function
REQ-020 Handshake: a transfer from requester i occurs when req_valid[i] and req_ready[i] are both high; that same cycle the operation is registered onto fpu_* with fpu_valid=1 on the next cycle.
REQ-021 Eligibility: requester i is eligible when req_valid[i]=1 and req_op[i]!=11.
REQ-022 Arbitration: round-robin from rr_ptr upward with wrap; the granted index g drives req_ready[g]; rr_ptr becomes (g+1) mod NUM_REQ after each grant and is unchanged when there is no grant.
REQ-023 Credits: out_cnt counts in-flight operations; +1 on issue, -1 on fpu_res_valid, unchanged when both occur in the same cycle; no grant while out_cnt==MAX_OUT, unless fpu_res_valid is high that cycle.
REQ-024 Reserved opcode: for a requester with req_op=11 and req_valid=1, req_ready is pulsed for one cycle without issuing to the FP unit; rsp_valid[i] follows one cycle later with rsp_data=0x7FC00000 (quiet NaN); this uses no credit and takes its round-robin turn.
REQ-025 Response: rsp_valid[fpu_res_tag]=1 and rsp_data=fpu_res one cycle after fpu_res_valid; this takes priority over the reserved-opcode NaN response, which waits while the output is busy, and no grant is made to a reserved-opcode requester while a NaN response is pending.
REQ-026 FSM with states RUN, DRAIN and FLUSHED; RUN goes to DRAIN on flush=1; DRAIN goes to FLUSHED when out_cnt==0 and no NaN response is pending; FLUSHED goes to RUN when flush=0; DRAIN goes to RUN if flush drops before drained.
REQ-027 Grants occur only in RUN; flush_done=1 only in FLUSHED.
REQ-028 An fpu_res_valid arriving when out_cnt==0 is dropped, and the sticky flag err_underflow (an internal register probed by the bench) is set.

Reset
REQ-029 On rst: req_ready=0, fpu_valid=0, fpu_a, fpu_b, fpu_op and fpu_tag=0, rsp_valid=0, rsp_data=0, flush_done=0, out_cnt=0, rr_ptr=0, FSM=RUN, err_underflow=0, pending NaN cleared.
REQ-030 Reset mid-operation discards in-flight tags; results returned by the FP unit after reset fall under REQ-028.

Configuration
REQ-031 Macro FP_SCHED_STATS_EN: when defined, adds outputs stat_issue (32), a wrapping count of FP unit issues, and stat_stall (32), a count of cycles with an eligible requester but no grant due to credits or flush; both are cleared by rst; when undefined, these ports and counters are absent.

Verification
REQ-032 Single requester 0 issues add 0x3F800000+0x40000000 -> fpu_valid one cycle later with tag 0; the bench FP unit returns 0x40400000 -> rsp_valid=0001, rsp_data=0x40400000.
REQ-033 All four requesters held valid for 8 cycles with MAX_OUT large -> grant order 0,1,2,3,0,1,2,3.
REQ-034 MAX_OUT=2, FP unit latency 5, continuous requests -> at most 2 issues per 5-cycle window, and a grant occurs in the same cycle a result returns at full credit.
REQ-035 Requester 2 uses op=11 in the same cycle as a result for tag 1 -> rsp_valid=0010 first, then 0100 with 0x7FC00000; out_cnt is unchanged by op=11.
REQ-036 flush asserted with 3 operations in flight -> no new grants, flush_done rises one cycle after the last result, and it falls after flush deasserts.
REQ-037 rst asserted with 2 operations in flight, then 2 late results -> no rsp_valid and err_underflow=1.
